// File: rtl/f_to_d_pipe.sv
// rtl/f_to_d_pipe.sv - fetch-to-decode stage with 2-entry skid buffer, flush and NOP injection
// Main entry drives D_*, the skid entry absorbs one instruction while decode stalls.
module f_to_d_pipe #(
  parameter int                  XLEN     = 32,
  parameter int                  PC_BITS  = 5,
  parameter logic [XLEN-1:0]     NOP_INST = XLEN'(32'h0000_0013),
  parameter int                  CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                F_valid,
  input  logic [PC_BITS-1:0]  F_pc,
  input  logic [XLEN-1:0]     F_inst,
  output logic                F_ready,
  input  logic                flush,
  input  logic                D_ready,
  output logic                D_valid,
  output logic [PC_BITS-1:0]  D_pc,
  output logic [XLEN-1:0]     D_inst,
  output logic [1:0]          occ,
  output logic [CNT_BITS-1:0] bubble_cnt
);

  logic                r_d_valid;
  logic [PC_BITS-1:0]  r_d_pc;
  logic [XLEN-1:0]     r_d_inst;
  logic                r_s_valid;
  logic [PC_BITS-1:0]  r_s_pc;
  logic [XLEN-1:0]     r_s_inst;
  logic                r_f_ready;
  logic [CNT_BITS-1:0] r_bubble_cnt;

  logic w_accept;
  logic w_drain;
  logic w_main_free;
  logic w_to_skid;
  logic w_s_valid_nxt;
  logic w_cnt_max;

  assign w_accept    = F_valid && r_f_ready;
  assign w_drain     = r_d_valid && D_ready;
  assign w_main_free = !r_d_valid || w_drain;
  assign w_to_skid   = w_accept && !w_main_free;
  assign w_cnt_max   = &r_bubble_cnt;

  // A free main entry always pulls the skid forward, so the skid can only stay or fill while main is stuck.
  assign w_s_valid_nxt = w_main_free ? 1'b0 : (r_s_valid || w_accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= '0;
      r_d_inst  <= NOP_INST;
    end else if (flush) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= '0;
      r_d_inst  <= NOP_INST;
    end else if (w_main_free) begin
      if (r_s_valid) begin
        r_d_valid <= 1'b1;
        r_d_pc    <= r_s_pc;
        r_d_inst  <= r_s_inst;
      end else if (w_accept) begin
        r_d_valid <= 1'b1;
        r_d_pc    <= F_pc;
        r_d_inst  <= F_inst;
      end else begin
        r_d_valid <= 1'b0;
        r_d_inst  <= NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_s_pc    <= '0;
      r_s_inst  <= NOP_INST;
      r_f_ready <= 1'b1;
    end else if (flush) begin
      r_s_valid <= 1'b0;
      r_f_ready <= 1'b1;
    end else begin
      if (w_to_skid) begin
        r_s_pc   <= F_pc;
        r_s_inst <= F_inst;
      end
      r_s_valid <= w_s_valid_nxt;
      r_f_ready <= !w_s_valid_nxt;
    end
  end

  // Counts idle decode cycles, including flush cycles, and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!r_d_valid && !w_cnt_max) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign F_ready    = r_f_ready;
  assign D_valid    = r_d_valid;
  assign D_pc       = r_d_pc;
  assign D_inst     = r_d_inst;
  assign occ        = {1'b0, r_d_valid} + {1'b0, r_s_valid};
  assign bubble_cnt = r_bubble_cnt;

  a_no_skid_overflow: assert property (@(posedge clk) disable iff (rst) !(w_accept && r_s_valid));

endmodule

// File: tb/tb_f_to_d_pipe.sv
// tb/tb_f_to_d_pipe.sv - self-checking bench for f_to_d_pipe against a queue-based model
module tb_f_to_d_pipe;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        F_valid = 1'b0;
  logic [4:0]  F_pc = '0;
  logic [31:0] F_inst = '0;
  logic        flush = 1'b0;
  logic        D_ready = 1'b0;
  logic        F_ready;
  logic        D_valid;
  logic [4:0]  D_pc;
  logic [31:0] D_inst;
  logic [1:0]  occ;
  logic [15:0] bubble_cnt;

  logic        rst2 = 1'b1;
  logic        F_ready2;
  logic        D_valid2;
  logic [4:0]  D_pc2;
  logic [31:0] D_inst2;
  logic [1:0]  occ2;
  logic [2:0]  bubble_cnt2;

  f_to_d_pipe dut (
    .clk(clk), .rst(rst), .F_valid(F_valid), .F_pc(F_pc), .F_inst(F_inst),
    .F_ready(F_ready), .flush(flush), .D_ready(D_ready), .D_valid(D_valid),
    .D_pc(D_pc), .D_inst(D_inst), .occ(occ), .bubble_cnt(bubble_cnt)
  );

  f_to_d_pipe #(.CNT_BITS(3)) dut_sat (
    .clk(clk), .rst(rst2), .F_valid(1'b0), .F_pc(5'd0), .F_inst(32'd0),
    .F_ready(F_ready2), .flush(1'b0), .D_ready(1'b1), .D_valid(D_valid2),
    .D_pc(D_pc2), .D_inst(D_inst2), .occ(occ2), .bubble_cnt(bubble_cnt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two instructions; the head is what decode sees.
  typedef struct packed { logic [4:0] pc; logic [31:0] inst; } ent_t;
  ent_t       mq[$];
  int         m_bub = 0;
  logic [4:0] m_hold = '0;
  logic       m_acc_last = 1'b0;

  always @(posedge clk) begin
    logic acc, drn;
    m_acc_last = 1'b0;
    if (rst) begin
      mq.delete();
      m_bub  = 0;
      m_hold = '0;
    end else begin
      if (mq.size() == 0 && m_bub < 65535) m_bub++;
      if (flush) begin
        mq.delete();
        m_hold = '0;
      end else begin
        acc = F_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && D_ready;
        if (drn) begin
          m_hold = mq[0].pc;
          void'(mq.pop_front());
        end
        if (acc) mq.push_back({F_pc, F_inst});
        m_acc_last = acc;
      end
    end
  end

  bit chk_en = 0;
  bit watch9 = 0;
  bit saw9   = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d_valid", D_valid, mq.size() > 0);
      chk("d_pc",    D_pc,    mq.size() > 0 ? mq[0].pc   : m_hold);
      chk("d_inst",  D_inst,  mq.size() > 0 ? mq[0].inst : NOP);
      chk("f_ready", F_ready, mq.size() < 2);
      chk("occ",     occ,     mq.size());
      chk("bubble",  bubble_cnt, m_bub);
    end
    if (watch9 && D_valid && D_pc == 5'd9) saw9 = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] pc, input logic [31:0] inst);
    F_valid = v;
    F_pc    = pc;
    F_inst  = inst;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1; D_ready = 1'b0; offer(0, 0, 0);
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_d_valid", D_valid, 0);
      chk("idle_d_inst",  D_inst, NOP);
      chk("idle_f_ready", F_ready, 1);
      chk("idle_occ",     occ, 0);
    end
    chk("idle_bubble5", bubble_cnt, 5);

    // Streaming
    D_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1, 5'(i), 32'hA0 + 32'(i));
      step();
      chk("stream_valid", D_valid, 1);
      chk("stream_pc",    D_pc, i);
      chk("stream_inst",  D_inst, 32'hA0 + 32'(i));
    end
    offer(0, 0, 0);
    step();

    // Stall fills skid, then release
    D_ready = 1'b0;
    offer(1, 5'd1, 32'hB1); step();
    offer(1, 5'd2, 32'hB2); step();
    chk("stall_occ2",    occ, 2);
    chk("stall_fready0", F_ready, 0);
    offer(1, 5'd3, 32'hB3); step();
    chk("stall_hold_pc1", D_pc, 1);
    chk("stall_still2",   occ, 2);
    D_ready = 1'b1; step();
    chk("release_pc2",    D_pc, 2);
    chk("release_fready", F_ready, 1);
    step();
    chk("release_pc3",    D_pc, 3);
    offer(0, 0, 0); step();
    chk("release_empty",  D_valid, 0);

    // Flush with a full buffer; PC 9 offered with the flush must vanish
    D_ready = 1'b0;
    offer(1, 5'd4, 32'hC4); step();
    offer(1, 5'd5, 32'hC5); step();
    chk("flush_pre_occ2", occ, 2);
    watch9 = 1;
    flush = 1'b1; offer(1, 5'd9, 32'hC9); step();
    flush = 1'b0;
    chk("flush_d_valid", D_valid, 0);
    chk("flush_occ",     occ, 0);
    chk("flush_nop",     D_inst, NOP);
    chk("flush_fready",  F_ready, 1);
    D_ready = 1'b1;
    offer(1, 5'd10, 32'hCA); step();
    chk("post_flush_valid", D_valid, 1);
    chk("post_flush_pc10",  D_pc, 10);
    offer(0, 0, 0); step(); step();
    watch9 = 0;
    chk("flush_pc9_never", saw9, 0);

    // Reset mid-stall
    D_ready = 1'b0;
    offer(1, 5'd11, 32'hD1); step();
    offer(1, 5'd12, 32'hD2); step();
    chk("rst_pre_occ2", occ, 2);
    rst = 1'b1; step();
    rst = 1'b0; offer(0, 0, 0);
    chk("rst_d_valid", D_valid, 0);
    chk("rst_d_pc",    D_pc, 0);
    chk("rst_d_inst",  D_inst, NOP);
    chk("rst_f_ready", F_ready, 1);
    chk("rst_occ",     occ, 0);
    chk("rst_bubble",  bubble_cnt, 0);

    // Randomised traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(199) == 0);
      flush   = ($urandom_range(24) == 0);
      D_ready = ($urandom_range(3) != 0);
      if (!(F_valid && !m_acc_last)) begin
        F_valid = $urandom_range(3) != 0;
        F_pc    = 5'($urandom);
        F_inst  = $urandom;
      end
      step();
    end
    rst = 1'b0; flush = 1'b0; offer(0, 0, 0);
    step();

    // Counter saturation on the 3-bit instance
    rst2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sat_bubble", bubble_cnt2, (k < 7) ? k : 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
